// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase sequencer: lamp drive, per-phase tick countdown,
// pedestrian request latch with main-green shortening, and night flashing mode.
module traffic_phase_controller #(
    parameter int T_GREEN_MAIN = 30,
    parameter int T_GREEN_SIDE = 20,
    parameter int T_YELLOW     = 4,
    parameter int T_ALLRED     = 2,
    parameter int T_PED_CUT    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase,
    output logic [6:0] time_remaining,
    output logic       phase_done
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5,
        FLASH       = 3'd6,
        ILLEGAL     = 3'd7
    } state_t;

    // A zero duration is treated as one tick so every phase is visible.
    localparam logic [6:0] D_GM = (T_GREEN_MAIN[6:0] == 7'd0) ? 7'd1 : T_GREEN_MAIN[6:0];
    localparam logic [6:0] D_GS = (T_GREEN_SIDE[6:0] == 7'd0) ? 7'd1 : T_GREEN_SIDE[6:0];
    localparam logic [6:0] D_Y  = (T_YELLOW[6:0]     == 7'd0) ? 7'd1 : T_YELLOW[6:0];
    localparam logic [6:0] D_AR = (T_ALLRED[6:0]     == 7'd0) ? 7'd1 : T_ALLRED[6:0];
    localparam logic [6:0] D_PC = (T_PED_CUT[6:0]    == 7'd0) ? 7'd1 : T_PED_CUT[6:0];

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    state_t     state, state_n;
    logic [6:0] rem, rem_n;
    logic       flash, flash_n;
    logic       pend_n;
    logic       expire;
    logic [2:0] main_n, side_n;

    assign expire = tick && (rem <= 7'd1);

    always_comb begin
        state_n = state;
        rem_n   = rem;
        flash_n = flash;
        if (tick && rem > 7'd1)
            rem_n = rem - 7'd1;
        case (state)
            MAIN_GREEN: begin
                if (ped_pending && rem > D_PC) begin
                    rem_n = D_PC;
                end else if (expire) begin
                    state_n = MAIN_YELLOW;
                    rem_n   = D_Y;
                end
            end
            MAIN_YELLOW: if (expire) begin
                state_n = ALL_RED_A;
                rem_n   = D_AR;
            end
            ALL_RED_A, ALL_RED_B: if (expire) begin
                if (night) begin
                    state_n = FLASH;
                    rem_n   = 7'd0;
                    flash_n = 1'b0;
                end else if (state == ALL_RED_A) begin
                    state_n = SIDE_GREEN;
                    rem_n   = D_GS;
                end else begin
                    state_n = MAIN_GREEN;
                    rem_n   = D_GM;
                end
            end
            SIDE_GREEN: if (expire) begin
                state_n = SIDE_YELLOW;
                rem_n   = D_Y;
            end
            SIDE_YELLOW: if (expire) begin
                state_n = ALL_RED_B;
                rem_n   = D_AR;
            end
            FLASH: begin
                rem_n = 7'd0;
                if (tick) begin
                    if (!night) begin
                        state_n = ALL_RED_B;
                        rem_n   = D_AR;
                        flash_n = 1'b0;
                    end else begin
                        flash_n = ~flash;
                    end
                end
            end
            default: begin
                state_n = ALL_RED_B;
                rem_n   = D_AR;
                flash_n = 1'b0;
            end
        endcase

        // A request arriving on the serving edge is kept for the next cycle.
        pend_n = ped_req ||
                 (ped_pending && !(state_n == SIDE_GREEN && state != SIDE_GREEN));

        main_n = RED;
        side_n = RED;
        case (state_n)
            MAIN_GREEN:  main_n = GREEN;
            MAIN_YELLOW: main_n = YELLOW;
            SIDE_GREEN:  side_n = GREEN;
            SIDE_YELLOW: side_n = YELLOW;
            FLASH: begin
                main_n = {1'b0, flash_n, 1'b0};
                side_n = {1'b0, flash_n, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ALL_RED_B;
            rem         <= D_AR;
            flash       <= 1'b0;
            main_light  <= RED;
            side_light  <= RED;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
            phase_done  <= 1'b0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            flash       <= flash_n;
            main_light  <= main_n;
            side_light  <= side_n;
            ped_walk    <= (state_n == SIDE_GREEN);
            ped_pending <= pend_n;
            phase_done  <= (state_n != state);
        end
    end

    assign phase          = state;
    assign time_remaining = rem;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with durations 6/4/2/1/2:
// a vector table for the base cycle plus hand sequences for ped, night and reset.
module tb_traffic_phase_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, ped_req = 1'b0, night = 1'b0;
    logic [2:0] main_light, side_light, phase;
    logic       ped_walk, ped_pending, phase_done;
    logic [6:0] time_remaining;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_controller #(
        .T_GREEN_MAIN(6), .T_GREEN_SIDE(4), .T_YELLOW(2), .T_ALLRED(1), .T_PED_CUT(2)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .ped_req(ped_req), .night(night),
        .main_light(main_light), .side_light(side_light), .ped_walk(ped_walk),
        .ped_pending(ped_pending), .phase(phase), .time_remaining(time_remaining),
        .phase_done(phase_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       t, p, n;
        logic [2:0] ph;
        logic [6:0] rem;
        logic [2:0] m, s;
        logic       walk, pend, done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic t, p, n, input logic [2:0] ph, input logic [6:0] rem,
                       input logic [2:0] m, s, input logic walk, pend, done);
        vec_t v;
        v.t = t; v.p = p; v.n = n; v.ph = ph; v.rem = rem;
        v.m = m; v.s = s; v.walk = walk; v.pend = pend; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic t, p, n);
        tick = t; ped_req = p; night = n;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic run_to(input logic [2:0] target, input string name);
        for (int i = 0; i < 200 && phase != target; i++) step(1, 0, 0);
        check(name, phase, target);
    endtask

    initial begin
        int cnt;

        // base cycle, tick every clock
        add(1,0,0, 0,6, 3'b001,3'b100, 0,0,1);
        add(1,0,0, 0,5, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 0,4, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 0,3, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 0,2, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 0,1, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 1,2, 3'b010,3'b100, 0,0,1);
        add(1,0,0, 1,1, 3'b010,3'b100, 0,0,0);
        add(1,0,0, 2,1, 3'b100,3'b100, 0,0,1);
        add(1,0,0, 3,4, 3'b100,3'b001, 1,0,1);
        add(1,0,0, 3,3, 3'b100,3'b001, 1,0,0);
        add(1,0,0, 3,2, 3'b100,3'b001, 1,0,0);
        add(1,0,0, 3,1, 3'b100,3'b001, 1,0,0);
        add(1,0,0, 4,2, 3'b100,3'b010, 0,0,1);
        add(1,0,0, 4,1, 3'b100,3'b010, 0,0,0);
        add(1,0,0, 5,1, 3'b100,3'b100, 0,0,1);
        add(1,0,0, 0,6, 3'b001,3'b100, 0,0,1);
        // tick every third clock: remaining holds in between
        add(0,0,0, 0,6, 3'b001,3'b100, 0,0,0);
        add(0,0,0, 0,6, 3'b001,3'b100, 0,0,0);
        add(1,0,0, 0,5, 3'b001,3'b100, 0,0,0);

        step(0, 0, 0);
        step(0, 0, 0);
        check("rst.phase", phase, 5);
        check("rst.rem", time_remaining, 1);
        check("rst.main", main_light, 3'b100);
        check("rst.side", side_light, 3'b100);
        check("rst.flags", {ped_walk, ped_pending, phase_done}, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].t, vecs[i].p, vecs[i].n);
            check($sformatf("row%0d.phase", i), phase, vecs[i].ph);
            check($sformatf("row%0d.rem", i), time_remaining, vecs[i].rem);
            check($sformatf("row%0d.main", i), main_light, vecs[i].m);
            check($sformatf("row%0d.side", i), side_light, vecs[i].s);
            check($sformatf("row%0d.walk", i), ped_walk, vecs[i].walk);
            check($sformatf("row%0d.pend", i), ped_pending, vecs[i].pend);
            check($sformatf("row%0d.done", i), phase_done, vecs[i].done);
        end

        // main green lasts 18 clocks when ticking every third clock
        cnt = 3;
        for (int i = 0; i < 100 && phase == 0; i++) begin
            step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
            cnt += 3;
        end
        check("slow.mg_cycles", cnt, 18);
        check("slow.phase", phase, 1);

        // pedestrian shortening and service
        do_reset();
        step(1, 0, 0);
        step(0, 1, 0);
        check("ped.latch", ped_pending, 1);
        check("ped.rem_before_cut", time_remaining, 6);
        step(0, 0, 0);
        check("ped.rem_cut", time_remaining, 2);
        step(1, 0, 0);
        check("ped.rem_dec", time_remaining, 1);
        step(1, 0, 0);
        check("ped.to_yellow", phase, 1);
        run_to(2, "ped.to_allred_a");
        step(1, 0, 0);
        check("ped.sg_entry", phase, 3);
        check("ped.cleared", ped_pending, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ped.walk%0d", k), ped_walk, 1);
            check($sformatf("ped.sgrem%0d", k), time_remaining, 4 - k);
            step(1, 0, 0);
        end
        check("ped.walk_off", ped_walk, 0);
        run_to(2, "ped.again_allred_a");
        step(1, 1, 0);
        check("ped.set_wins", ped_pending, 1);
        check("ped.set_wins_phase", phase, 3);

        // request at remaining=1 never increases the count
        do_reset();
        step(1, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 0, 0);
        check("late.rem1", time_remaining, 1);
        step(0, 1, 0);
        step(0, 0, 0);
        check("late.no_increase", time_remaining, 1);
        check("late.pending", ped_pending, 1);
        step(1, 0, 0);
        check("late.phase", phase, 1);
        check("late.rem", time_remaining, 2);

        // night flashing
        do_reset();
        run_to(2, "night.allred_a");
        step(1, 0, 1);
        check("night.phase", phase, 6);
        check("night.rem", time_remaining, 0);
        check("night.lamps0", {main_light, side_light}, 6'b000_000);
        check("night.done", phase_done, 1);
        step(0, 0, 1);
        check("night.hold", {main_light, side_light}, 6'b000_000);
        check("night.done_low", phase_done, 0);
        step(1, 0, 1);
        check("night.lamps1", {main_light, side_light}, 6'b010_010);
        step(1, 0, 1);
        check("night.lamps2", {main_light, side_light}, 6'b000_000);
        step(0, 0, 0);
        check("night.wait_tick", phase, 6);
        step(1, 0, 0);
        check("night.exit_phase", phase, 5);
        check("night.exit_rem", time_remaining, 1);
        check("night.exit_lamps", {main_light, side_light}, 6'b100_100);
        check("night.exit_done", phase_done, 1);
        step(1, 0, 0);
        check("night.mg", phase, 0);
        check("night.mg_rem", time_remaining, 6);

        // asynchronous reset mid side green
        do_reset();
        run_to(3, "arst.side_green");
        step(0, 1, 0);
        check("arst.pending_before", ped_pending, 1);
        #2 reset = 1'b1;
        #1;
        check("arst.phase", phase, 5);
        check("arst.lamps", {main_light, side_light}, 6'b100_100);
        check("arst.pending", ped_pending, 0);
        check("arst.rem", time_remaining, 1);
        check("arst.walk", ped_walk, 0);
        reset = 1'b0;

        // random stimulus: never both roads non-red outside flash
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) night = ~night;
            step($urandom_range(0, 1), ($urandom_range(0, 19) == 0), night);
            check("safety", (phase != 6) && (main_light != 3'b100) && (side_light != 3'b100), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Phase sequencer for the two-way intersection. It owns the phase state machine and a 7-bit per-phase countdown, and drives the main-road and side-road lamps.
- Adds a pedestrian request latch that shortens main green, and a night flashing-yellow mode.
- Time base is an external 1-cycle `tick` strobe, typically 1 Hz from the prescaler. `time_remaining` feeds the 7-segment countdown display.

Parameters:
- T_GREEN_MAIN, 30, main-road green duration in ticks (1..127).
- T_GREEN_SIDE, 20, side-road green duration in ticks (1..127).
- T_YELLOW, 4, yellow duration in ticks, both roads (1..127).
- T_ALLRED, 2, all-red clearance duration in ticks (1..127).
- T_PED_CUT, 5, maximum remaining main green once a pedestrian request is pending (1..127).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- tick  input  1  time-base strobe, one clock wide.
- ped_req  input  1  pedestrian button, pulse or level; sampled every clock.
- night  input  1  night-mode request, level.
- main_light  output  3  {red,yellow,green} for the main road, one-hot or 0.
- side_light  output  3  {red,yellow,green} for the side road.
- ped_walk  output  1  walk lamp.
- ped_pending  output  1  pedestrian request latched and not yet served.
- phase  output  3  current state encoding.
- time_remaining  output  7  ticks left in the current phase.
- phase_done  output  1  one-cycle pulse in the cycle after each state change.

Behaviour:
- Reset clock/reset: `reset` is asynchronous, active-high; `clock` is the system clock.
- State encodings: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_B=5, FLASH=6. Encoding 7 is illegal and recovers to ALL_RED_B with remaining=T_ALLRED.
- Reset values:
  - phase=ALL_RED_B, time_remaining=T_ALLRED.
  - main_light=side_light=3'b100.
  - ped_walk=0, ped_pending=0, phase_done=0, flash bit=0.
  - Reset mid-phase aborts immediately to these values; the pending request is discarded.
- Sequence: MAIN_GREEN -> MAIN_YELLOW -> ALL_RED_A -> SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_B -> MAIN_GREEN.
- Countdown: on entry, remaining loads that state's duration. On a clock with tick=1:
  - if remaining<=1, the state advances on that edge and remaining loads the next duration;
  - else remaining decrements by 1.
  - Without tick, remaining holds. Each phase therefore lasts exactly its duration in ticks.
- Durations are 7-bit. A parameter value of 0 behaves as 1. Arithmetic never wraps below 0.
- Lamps (registered, change on the same edge as the state):
  - MAIN_GREEN: main=001, side=100.
  - MAIN_YELLOW: main=010, side=100.
  - ALL_RED_A/B: both 100.
  - SIDE_GREEN: main=100, side=001.
  - SIDE_YELLOW: main=100, side=010.
  - FLASH: both = {0,flash,0}.
- Pedestrian latch:
  - ped_req=1 sets ped_pending.
  - ped_pending clears on the edge that enters SIDE_GREEN. If ped_req=1 on that same edge, set wins: pending stays 1 for the next cycle.
  - ped_walk=1 exactly while phase=SIDE_GREEN.
- Green shortening: while in MAIN_GREEN with ped_pending=1 and remaining>T_PED_CUT, remaining loads T_PED_CUT on the next edge.
  - Shortening takes precedence over tick decrement in that cycle.
  - Remaining is never increased.
- Night mode:
  - `night` is sampled only on the edge leaving ALL_RED_A or ALL_RED_B. If night=1, go to FLASH instead of the next green.
  - In FLASH, time_remaining=0 and the flash bit toggles on each tick.
  - On a tick with night=0, exit to ALL_RED_B with remaining=T_ALLRED and flash=0.
  - ped_pending stays latched through FLASH; shortening applies only in MAIN_GREEN.
- phase_done: registered, 1 for exactly one cycle after any state change, including FLASH entry and exit.
- Safety invariant: main and side are never simultaneously non-red outside FLASH.

Test Plan:
1. Params 6/4/2/1/2, tick every cycle, no ped_req/night; release reset -> phases 5,0,2? Corrected order: phases 5,0,1,2,3,4,5,0 dwelling 1,6,2,1,4,2,1 cycles; period 16 cycles; phase_done pulses once per change; time_remaining counts 6..1 in MAIN_GREEN.
2. Same params, tick every 3rd cycle -> every dwell triples; remaining holds between ticks; MAIN_GREEN=18 cycles.
3. ped_req pulse when MAIN_GREEN remaining=6 -> next cycle remaining=2; MAIN_YELLOW follows 2 ticks later; ped_walk=1 for all 4 SIDE_GREEN ticks; ped_pending clears on SIDE_GREEN entry. Repeat with ped_req asserted on the SIDE_GREEN entry edge -> ped_pending=1 afterwards.
4. ped_req when remaining=1 -> no change; normal transition; remaining never increases.
5. night=1 during ALL_RED_A exit edge -> phase=6, lamps 000/010 alternate per tick, time_remaining=0. Drop night -> next tick enters ALL_RED_B, then MAIN_GREEN.
6. Assert reset mid SIDE_GREEN with ped_pending=1 -> immediately phase=5, both lamps 100, ped_pending=0, time_remaining=1. Random-stimulus assertion: never both lamps non-red outside FLASH.
